// File: rtl/rf_wb_if.sv
// rf_wb_if: writeback bus between the two writeback sources / hazard logic
// and the register-file write-port arbiter.
//   p_*        pipeline WB request (no ready, always accepted)
//   m_*        MDU result handshake (valid/ready)
//   iss_*      MDU issue notification feeding the pending scoreboard
//   rf_*       registered register-file write port
//   pending    per-register "MDU write outstanding" bits
//   stall_req  one-cycle request for the pipeline to present no WB write
//   fifo_count MDU result FIFO occupancy
// Modports: master = sources / consumers, slave = arbiter.
interface rf_wb_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          p_valid;
    logic [4:0]    p_waddr;
    logic [31:0]   p_wdata;
    logic          m_valid;
    logic          m_ready;
    logic [4:0]    m_waddr;
    logic [31:0]   m_wdata;
    logic          iss_valid;
    logic [4:0]    iss_waddr;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [31:0]   pending;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    modport master (
        output p_valid, p_waddr, p_wdata,
        output m_valid, m_waddr, m_wdata,
        output iss_valid, iss_waddr,
        input  m_ready, rf_we, rf_waddr, rf_wdata, pending, stall_req, fifo_count
    );

    modport slave (
        input  p_valid, p_waddr, p_wdata,
        input  m_valid, m_waddr, m_wdata,
        input  iss_valid, iss_waddr,
        output m_ready, rf_we, rf_waddr, rf_wdata, pending, stall_req, fifo_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the
// pipeline WB stage (priority) and buffered MDU results.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        rf_wb_if.slave (pipeline request, MDU handshake, issue info,
//              registered RF write, pending scoreboard, stall_req, fifo_count)
// Optional (macro RF_WB_STATS_EN):
//   conflict_cnt  cycles with pipeline write while the FIFO held results
//   stall_cnt     number of stall_req pulses
// Parameters: DEPTH (power of 2, >= 2), STARVE_MAX (>= 1).
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    rf_wb_if.slave      bus
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0] conflict_cnt,
    output logic [31:0] stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_ent_t;

    wb_ent_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, push, pop, conflict, stall_fire;
    wb_ent_t        head;

    logic           rf_we_q;
    logic [4:0]     rf_waddr_q;
    logic [31:0]    rf_wdata_q;
    logic [31:0]    pending_q, pending_nxt;
    logic           stall_q;
    logic [SW-1:0]  starve_cnt;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // m_ready ignores a same-cycle pop so a full FIFO never refills in one cycle
    assign bus.m_ready = !full && !rst;
    assign push        = bus.m_valid && bus.m_ready;
    assign pop         = !bus.p_valid && !empty;
    assign conflict    = bus.p_valid && !empty;
    assign stall_fire  = conflict && (starve_cnt == SW'(STARVE_MAX - 1));

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.pending    = pending_q;
    assign bus.stall_req  = stall_q;
    assign bus.fifo_count = count;

    // storage needs no reset; occupancy is tracked by count/pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{waddr: bus.m_waddr, wdata: bus.m_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // registered write port; idle cycles hold addr/data
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (bus.p_valid) begin
            rf_we_q    <= (bus.p_waddr != 5'd0);
            rf_waddr_q <= bus.p_waddr;
            rf_wdata_q <= bus.p_wdata;
        end else if (pop) begin
            rf_we_q    <= (head.waddr != 5'd0);
            rf_waddr_q <= head.waddr;
            rf_wdata_q <= head.wdata;
        end else begin
            rf_we_q    <= 1'b0;
        end
    end

    // starvation guard: pop or empty FIFO both imply !conflict, so one clear term
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= stall_fire;
            if (!conflict || stall_fire) starve_cnt <= '0;
            else                         starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // scoreboard: clear on MDU pop, set on issue; set applied last so it wins
    always_comb begin
        pending_nxt = pending_q;
        if (pop && head.waddr != 5'd0)             pending_nxt[head.waddr]    = 1'b0;
        if (bus.iss_valid && bus.iss_waddr != 5'd0) pending_nxt[bus.iss_waddr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_nxt;
    end

`ifdef RF_WB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (conflict && conflict_cnt != '1)  conflict_cnt <= conflict_cnt + 1'b1;
            if (stall_fire && stall_cnt != '1)   stall_cnt    <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_if #(.DEPTH(DEPTH)) bus ();

`ifdef RF_WB_STATS_EN
    logic [31:0] conflict_cnt, stall_cnt;
`endif

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RF_WB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];   // expected RF writes, in order
    wr_t mq[$];      // reference copy of buffered MDU results

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // advance one clock; at the edge, apply the reference grant to the inputs
    // the DUT sampled and queue any resulting RF write
    task automatic cyc();
        wr_t h;
        bit  have, mrdy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            mrdy = (mq.size() < DEPTH);
            have = (mq.size() > 0);
            if (have) h = mq[0];
            if (bus.p_valid) begin
                if (bus.p_waddr != 5'd0) exp_q.push_back('{bus.p_waddr, bus.p_wdata});
            end else if (have) begin
                void'(mq.pop_front());
                if (h.a != 5'd0) exp_q.push_back(h);
            end
            if (bus.m_valid && mrdy) mq.push_back('{bus.m_waddr, bus.m_wdata});
        end
        #1;
    endtask

    // monitor: every presented RF write must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (bus.rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write_unexpected: got addr %0d data %0h expected none",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_waddr !== e.a || bus.rf_wdata !== e.d) begin
                    errors++;
                    $display("FAIL rf_write: got addr %0d data %0h expected addr %0d data %0h",
                             bus.rf_waddr, bus.rf_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic zero_inputs();
        bus.p_valid = 0; bus.p_waddr = 0; bus.p_wdata = 0;
        bus.m_valid = 0; bus.m_waddr = 0; bus.m_wdata = 0;
        bus.iss_valid = 0; bus.iss_waddr = 0;
    endtask

    initial begin
        // reset held 2 cycles with an MDU result offered
        zero_inputs();
        rst = 1;
        bus.m_valid = 1; bus.m_waddr = 5'd3; bus.m_wdata = 32'h33;
        cyc(); cyc();
        chk("rst_m_ready", 32'(bus.m_ready), 0);
        chk("rst_rf_we", 32'(bus.rf_we), 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_count", 32'(bus.fifo_count), 0);
        rst = 0; bus.m_valid = 0;
        #1;
        chk("m_ready_after_rst", 32'(bus.m_ready), 1);

        // pipeline-only path
        bus.p_valid = 1; bus.p_waddr = 5'd5; bus.p_wdata = 32'hDEADBEEF;
        cyc();
        chk("p_we", 32'(bus.rf_we), 1);
        chk("p_waddr", 32'(bus.rf_waddr), 5);
        chk("p_wdata", bus.rf_wdata, 32'hDEADBEEF);
        bus.p_waddr = 5'd0; bus.p_wdata = 32'h1234;
        cyc();
        chk("p_x0_no_we", 32'(bus.rf_we), 0);
        bus.p_valid = 0;

        // MDU path plus scoreboard
        bus.iss_valid = 1; bus.iss_waddr = 5'd7;
        cyc();
        bus.iss_valid = 0;
        chk("pend7_set", 32'(bus.pending[7]), 1);
        bus.m_valid = 1; bus.m_waddr = 5'd7; bus.m_wdata = 32'd42;
        cyc();
        bus.m_valid = 0;
        chk("m_count1", 32'(bus.fifo_count), 1);
        chk("m_no_bypass", 32'(bus.rf_we), 0);
        cyc();
        chk("m_count0", 32'(bus.fifo_count), 0);
        chk("m_we", 32'(bus.rf_we), 1);
        chk("m_waddr", 32'(bus.rf_waddr), 7);
        chk("m_wdata", bus.rf_wdata, 42);
        chk("pend7_clr", 32'(bus.pending[7]), 0);

        // fill FIFO while pipeline holds the port; starvation pulse after 3 conflicts
        bus.p_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.p_waddr = 5'(10 + i); bus.p_wdata = 32'h100 + i;
            bus.m_valid = 1; bus.m_waddr = 5'(16 + i); bus.m_wdata = 32'hA000 + i;
            chk("fill_m_ready", 32'(bus.m_ready), 1);
            cyc();
            if (i == 2) chk("stall_before", 32'(bus.stall_req), 0);
        end
        chk("full_count", 32'(bus.fifo_count), 4);
        chk("full_m_ready", 32'(bus.m_ready), 0);
        chk("stall_pulse", 32'(bus.stall_req), 1);
        // fifth result offered while full: must not be accepted
        bus.p_waddr = 5'd14; bus.p_wdata = 32'h104;
        bus.m_waddr = 5'd31; bus.m_wdata = 32'hBAD;
        cyc();
        chk("full_hold_count", 32'(bus.fifo_count), 4);
        chk("stall_one_cycle", 32'(bus.stall_req), 0);
        bus.p_valid = 0; bus.m_valid = 0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("drain_we", 32'(bus.rf_we), 1);
            chk("drain_waddr", 32'(bus.rf_waddr), 32'(16 + j));
            chk("drain_count", 32'(bus.fifo_count), 32'(3 - j));
        end
        cyc();
        chk("drain_idle", 32'(bus.rf_we), 0);

        // same-cycle pop of waddr 9 and issue to 9: set wins
        bus.iss_valid = 1; bus.iss_waddr = 5'd9;
        cyc();
        bus.iss_valid = 0;
        bus.m_valid = 1; bus.m_waddr = 5'd9; bus.m_wdata = 32'd99;
        cyc();
        bus.m_valid = 0;
        bus.iss_valid = 1; bus.iss_waddr = 5'd9;
        cyc();
        bus.iss_valid = 0;
        chk("pop9_we", 32'(bus.rf_we), 1);
        chk("pend9_kept", 32'(bus.pending[9]), 1);
        chk("pop9_count", 32'(bus.fifo_count), 0);

        // full FIFO: pop without same-cycle refill, then push+pop keeps the count
        bus.p_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.p_waddr = 5'd2; bus.p_wdata = 32'h200 + i;
            bus.m_valid = 1; bus.m_waddr = 5'(24 + i); bus.m_wdata = 32'hB000 + i;
            cyc();
        end
        chk("refull_count", 32'(bus.fifo_count), 4);
        bus.p_valid = 0;
        bus.m_waddr = 5'd21; bus.m_wdata = 32'hC0;
        chk("full_pop_m_ready", 32'(bus.m_ready), 0);
        cyc();
        chk("pop_no_refill", 32'(bus.fifo_count), 3);
        chk("pushpop_m_ready", 32'(bus.m_ready), 1);
        cyc();
        chk("pushpop_count", 32'(bus.fifo_count), 3);
        bus.m_valid = 0;
        for (int j = 0; j < 4; j++) cyc();
        chk("pushpop_drained", 32'(bus.fifo_count), 0);

        // mid-operation reset with 3 buffered results and pending 3,4,5 (+9)
        for (int i = 3; i <= 5; i++) begin
            bus.iss_valid = 1; bus.iss_waddr = 5'(i);
            cyc();
        end
        bus.iss_valid = 0;
        bus.p_valid = 1; bus.p_waddr = 5'd6; bus.p_wdata = 32'h66;
        for (int i = 3; i <= 5; i++) begin
            bus.m_valid = 1; bus.m_waddr = 5'(i); bus.m_wdata = 32'hD0 + i;
            cyc();
        end
        chk("pre_rst_count", 32'(bus.fifo_count), 3);
        chk("pre_rst_pending", bus.pending, 32'h0000_0238);
        zero_inputs();
        rst = 1;
        cyc();
        chk("mid_rst_we", 32'(bus.rf_we), 0);
        chk("mid_rst_pending", bus.pending, 0);
        chk("mid_rst_count", 32'(bus.fifo_count), 0);
        chk("mid_rst_m_ready", 32'(bus.m_ready), 0);
        rst = 0;
        cyc();
        chk("post_rst_we", 32'(bus.rf_we), 0);
        cyc();

        // 5 conflict cycles after a fresh reset
        bus.p_valid = 1; bus.p_waddr = 5'd2; bus.p_wdata = 32'h77;
        bus.m_valid = 1; bus.m_waddr = 5'd1; bus.m_wdata = 32'h11;
        cyc();
        bus.m_valid = 0;
        for (int i = 0; i < 5; i++) cyc();
`ifdef RF_WB_STATS_EN
        chk("conflict_cnt", conflict_cnt, 5);
        chk("stall_cnt", stall_cnt, 1);
`endif
        zero_inputs();
        cyc(); cyc(); cyc();
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
